// File: rtl/clkgen_pkg.sv
// Shared types, defaults and P/Q/R phase encodings for the four-phase clock generator.
package clkgen_pkg;

    localparam int unsigned DEF_PHASE_LEN = 8;
    localparam int unsigned DEF_GAP_LEN   = 2;
    localparam int unsigned DEF_BIT_COUNT = 14;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_W = 3'd1,
        PH_X = 3'd2,
        PH_Y = 3'd3,
        PH_Z = 3'd4
    } phase_t;

    typedef struct packed {
        logic p;
        logic q;
        logic r;
    } pqr_t;

    localparam pqr_t ENC_IDLE = 3'b000;
    localparam pqr_t ENC_W    = 3'b101;
    localparam pqr_t ENC_X    = 3'b011;
    localparam pqr_t ENC_Y    = 3'b110;
    localparam pqr_t ENC_Z    = 3'b000;

    // P/Q/R levels presented while in a given phase
    function automatic pqr_t phase_enc(input phase_t ph);
        pqr_t enc;
        enc = ENC_IDLE;
        case (ph)
            PH_W:    enc = ENC_W;
            PH_X:    enc = ENC_X;
            PH_Y:    enc = ENC_Y;
            PH_Z:    enc = ENC_Z;
            default: enc = ENC_IDLE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/clkgen_phase_timer.sv
// Per-phase cycle counter with registered terminal-count flag and next-cycle guard flag.
module clkgen_phase_timer
    import clkgen_pkg::*;
#(
    parameter int unsigned PHASE_LEN = DEF_PHASE_LEN,
    parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
    localparam int unsigned CW       = $clog2(PHASE_LEN)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_run,
    output logic [CW-1:0] o_count,
    output logic          o_tc,
    output logic          o_guard_nxt_c
);

    logic [CW-1:0] r_count;
    logic          r_tc;
    logic [CW-1:0] w_count_nxt;

    // Count only while a phase is active; terminal count folds back to zero
    always_comb begin
        w_count_nxt = '0;
        if (i_run && !r_tc) begin
            w_count_nxt = r_count + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= (w_count_nxt == CW'(PHASE_LEN - 1));
        end
    end

    assign o_count       = r_count;
    assign o_tc          = r_tc;
    assign o_guard_nxt_c = (w_count_nxt >= CW'(GAP_LEN));

endmodule

// File: rtl/clock_phase_generator.sv
// Four-phase (W/X/Y/Z) non-overlapping clock generator with bit/word timing.
// Optional stop request input enabled by defining CLKGEN_HALT_EN.
module clock_phase_generator
    import clkgen_pkg::*;
#(
    parameter int unsigned PHASE_LEN = DEF_PHASE_LEN,
    parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
    parameter int unsigned BIT_COUNT = DEF_BIT_COUNT,
    localparam int unsigned BCW      = $clog2(BIT_COUNT)
) (
    input  logic           CLK,
    input  logic           RST_N,
`ifdef CLKGEN_HALT_EN
    input  logic           HALT,
`endif
    output logic           CGPP,
    output logic           CGPPN,
    output logic           CGQP,
    output logic           CGQPN,
    output logic           CGRP,
    output logic           CGRPN,
    output logic           BOP,
    output logic [BCW-1:0] BIT_CNT,
    output logic           WORD_STROBE
);

    localparam int unsigned CW = $clog2(PHASE_LEN);

    phase_t         r_state;
    phase_t         w_state_nxt;
    logic [CW-1:0]  w_count;
    logic           w_tc;
    logic           w_guard_nxt;
    logic           w_halt_req;
    logic           w_bit_end;
    logic [BCW-1:0] w_bit_cnt_nxt;
    logic           w_strobe_nxt;
    logic           w_bop_nxt;
    pqr_t           w_enc;

    logic           r_cgpp, r_cgppn, r_cgqp, r_cgqpn, r_cgrp, r_cgrpn;
    logic           r_bop;
    logic [BCW-1:0] r_bit_cnt;
    logic           r_strobe;

`ifdef CLKGEN_HALT_EN
    assign w_halt_req = HALT;
`else
    assign w_halt_req = 1'b0;
`endif

    clkgen_phase_timer #(
        .PHASE_LEN (PHASE_LEN),
        .GAP_LEN   (GAP_LEN)
    ) u_timer (
        .i_clk         (CLK),
        .i_rst_n       (RST_N),
        .i_run         (r_state != IDLE),
        .o_count       (w_count),
        .o_tc          (w_tc),
        .o_guard_nxt_c (w_guard_nxt)
    );

    // Next phase; stop request only honoured at the end of a full bit time
    always_comb begin
        w_state_nxt = r_state;
        w_bit_end   = 1'b0;
        case (r_state)
            IDLE: if (!w_halt_req) w_state_nxt = PH_W;
            PH_W: if (w_tc) w_state_nxt = PH_X;
            PH_X: if (w_tc) w_state_nxt = PH_Y;
            PH_Y: if (w_tc) w_state_nxt = PH_Z;
            PH_Z: begin
                if (w_tc) begin
                    w_bit_end   = 1'b1;
                    w_state_nxt = w_halt_req ? IDLE : PH_W;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_bit_cnt_nxt = r_bit_cnt;
        if (w_bit_end) begin
            w_bit_cnt_nxt = (r_bit_cnt == BCW'(BIT_COUNT - 1)) ? '0 : r_bit_cnt + BCW'(1);
        end

        w_enc        = phase_enc(w_state_nxt);
        w_bop_nxt    = (w_state_nxt != IDLE) && w_guard_nxt;
        // Fires one cycle early so the registered pulse lands on the last Z cycle
        w_strobe_nxt = (r_state == PH_Z) && (w_count == CW'(PHASE_LEN - 2)) &&
                       (r_bit_cnt == BCW'(BIT_COUNT - 1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_cgpp    <= 1'b0;
            r_cgppn   <= 1'b1;
            r_cgqp    <= 1'b0;
            r_cgqpn   <= 1'b1;
            r_cgrp    <= 1'b0;
            r_cgrpn   <= 1'b1;
            r_bop     <= 1'b0;
            r_bit_cnt <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cgpp    <= w_enc.p;
            r_cgppn   <= ~w_enc.p;
            r_cgqp    <= w_enc.q;
            r_cgqpn   <= ~w_enc.q;
            r_cgrp    <= w_enc.r;
            r_cgrpn   <= ~w_enc.r;
            r_bop     <= w_bop_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_strobe  <= w_strobe_nxt;
        end
    end

    assign CGPP        = r_cgpp;
    assign CGPPN       = r_cgppn;
    assign CGQP        = r_cgqp;
    assign CGQPN       = r_cgqpn;
    assign CGRP        = r_cgrp;
    assign CGRPN       = r_cgrpn;
    assign BOP         = r_bop;
    assign BIT_CNT     = r_bit_cnt;
    assign WORD_STROBE = r_strobe;

endmodule

// File: tb/tb_clock_phase_generator.sv
// Scoreboard bench for clock_phase_generator at default parameters (8/2/14).
// Extra stop-request scenarios run when CLKGEN_HALT_EN is defined.
module tb_clock_phase_generator;

    typedef struct packed {
        logic       p;
        logic       pn;
        logic       q;
        logic       qn;
        logic       r;
        logic       rn;
        logic       bop;
        logic [3:0] bcnt;
        logic       strobe;
    } rec_t;

    logic       CLK;
    logic       RST_N;
`ifdef CLKGEN_HALT_EN
    logic       HALT;
`endif
    logic       CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN;
    logic       BOP;
    logic [3:0] BIT_CNT;
    logic       WORD_STROBE;

    rec_t sb_q[$];
    int   id_q[$];
    int   total;
    int   bad;
    logic done;

    clock_phase_generator dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
`ifdef CLKGEN_HALT_EN
        .HALT        (HALT),
`endif
        .CGPP        (CGPP),
        .CGPPN       (CGPPN),
        .CGQP        (CGQP),
        .CGQPN       (CGQPN),
        .CGRP        (CGRP),
        .CGRPN       (CGRPN),
        .BOP         (BOP),
        .BIT_CNT     (BIT_CNT),
        .WORD_STROBE (WORD_STROBE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic rec_t mk(input logic p, input logic q, input logic r,
                                input logic bop, input logic [3:0] bcnt, input logic strobe);
        rec_t e;
        e.p = p;  e.pn = ~p;
        e.q = q;  e.qn = ~q;
        e.r = r;  e.rn = ~r;
        e.bop    = bop;
        e.bcnt   = bcnt;
        e.strobe = strobe;
        return e;
    endfunction

    // Expected outputs n cycles after the edge that first enters PH_W
    function automatic rec_t exp_run(input int n);
        int ph;
        int c;
        ph = (n / 8) % 4;
        c  = n % 8;
        case (ph)
            0:       return mk(1'b1, 1'b0, 1'b1, c >= 2, 4'((n / 32) % 14), (n % 448) == 447);
            1:       return mk(1'b0, 1'b1, 1'b1, c >= 2, 4'((n / 32) % 14), (n % 448) == 447);
            2:       return mk(1'b1, 1'b1, 1'b0, c >= 2, 4'((n / 32) % 14), (n % 448) == 447);
            default: return mk(1'b0, 1'b0, 1'b0, c >= 2, 4'((n / 32) % 14), (n % 448) == 447);
        endcase
    endfunction

    task automatic push(input rec_t e, input int id);
        sb_q.push_back(e);
        id_q.push_back(id);
    endtask

    // Monitor: every falling edge, compare against the oldest pending expectation
    initial begin
        rec_t exp_r;
        rec_t act;
        int   id;
        total = 0;
        bad   = 0;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                exp_r = sb_q.pop_front();
                id    = id_q.pop_front();
                act   = {CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN, BOP, BIT_CNT, WORD_STROBE};
                total++;
                if (act !== exp_r) begin
                    bad++;
                    $display("FAIL chk%0d: got pPqQrR=%b bop=%b bit=%0d strb=%b, want pPqQrR=%b bop=%b bit=%0d strb=%b",
                             id, {act.p, act.pn, act.q, act.qn, act.r, act.rn}, act.bop, act.bcnt, act.strobe,
                             {exp_r.p, exp_r.pn, exp_r.q, exp_r.qn, exp_r.r, exp_r.rn}, exp_r.bop, exp_r.bcnt,
                             exp_r.strobe);
                end
            end
            if (done) begin
                total++;
                if (sb_q.size() != 0) begin
                    bad++;
                    $display("FAIL drain: got %0d pending, want 0", sb_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: expectations pushed at each rising edge, checked at the following falling edge
    initial begin
        rec_t rst_rec;
        rst_rec = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        done  = 1'b0;
        RST_N = 1'b0;
`ifdef CLKGEN_HALT_EN
        HALT  = 1'b0;
`endif
        repeat (3) begin
            @(posedge CLK);
            push(rst_rec, 10000);
        end
        // Released mid-cycle: still idle until the next edge
        @(posedge CLK);
        push(rst_rec, 10001);
        #2 RST_N = 1'b1;

        // Free run through one full word and into the next
        for (int n = 0; n <= 460; n++) begin
            @(posedge CLK);
            push(exp_run(n), 20000 + n);
        end

        // This edge enters PH_X count 5; reset must clear outputs before the next edge
        @(posedge CLK);
        #2 RST_N = 1'b0;
        push(rst_rec, 30000);
        @(posedge CLK);
        push(rst_rec, 30001);
        @(posedge CLK);
        push(rst_rec, 30002);
        #2 RST_N = 1'b1;

`ifdef CLKGEN_HALT_EN
        // Stop requested in PH_X of bit 3: bit completes, then idle with bit count 4
        for (int n = 0; n <= 127; n++) begin
            @(posedge CLK);
            push(exp_run(n), 40000 + n);
            if (n == 107) begin
                #2 HALT = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            push(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0), 50000 + k);
        end
        #2 HALT = 1'b0;
        // Resume at PH_W; a stop pulse confined to PH_W of bit 5 is ignored
        for (int n = 128; n <= 200; n++) begin
            @(posedge CLK);
            push(exp_run(n), 60000 + n);
            if (n == 161) begin
                #2 HALT = 1'b1;
            end
            if (n == 166) begin
                #2 HALT = 1'b0;
            end
        end
`else
        for (int n = 0; n <= 40; n++) begin
            @(posedge CLK);
            push(exp_run(n), 40000 + n);
        end
`endif

        @(posedge CLK);
        #1 done = 1'b1;
    end

endmodule

// File: doc/clock_phase_generator.md
CLOCK_PHASE_GENERATOR -- requirements
Module: clock_phase_generator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter PHASE_LEN, default 8: master cycles per phase (W, X, Y or Z); legal range 4..64.
REQ-003 Parameter GAP_LEN, default 2: cycles at each phase start with BOP low (non-overlap guard); legal range 1..PHASE_LEN-2.
REQ-004 Parameter BIT_COUNT, default 14: bit times per word.
REQ-005 Port CLK, input, 1 bit: master oscillator clock; all state changes on the rising edge.
REQ-006 Port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-007 Port HALT, input, 1 bit: stop request; present only when CLKGEN_HALT_EN is defined.
REQ-008 Ports CGPP and CGPPN, outputs, 1 bit each: P phase flop and its complement.
REQ-009 Ports CGQP and CGQPN, outputs, 1 bit each: Q phase flop and its complement.
REQ-010 Ports CGRP and CGRPN, outputs, 1 bit each: R phase flop and its complement.
REQ-011 Port BOP, output, 1 bit: clock-driver enable; gates all four W/X/Y/Z drivers.
REQ-012 Port BIT_CNT, output, $clog2(BIT_COUNT) bits: current bit time within the word.
REQ-013 Port WORD_STROBE, output, 1 bit: one-cycle end-of-word pulse.

Function
REQ-014 The state machine SHALL have the states IDLE, PH_W, PH_X, PH_Y and PH_Z.
REQ-015 The P/Q/R encoding SHALL be:
- PH_W: P=1, Q=0, R=1
- PH_X: P=0, Q=1, R=1
- PH_Y: P=1, Q=1, R=0
- PH_Z: P=0, Q=0, R=0
- IDLE: P=0, Q=0, R=0
REQ-016 CGxxN SHALL always equal the inverse of CGxx; all outputs SHALL be registered.
REQ-017 The phase counter SHALL run 0..PHASE_LEN-1 in each phase.
REQ-018 On the edge after count PHASE_LEN-1, the state SHALL advance W->X->Y->Z->W and the counter SHALL reset to 0.
REQ-019 BOP SHALL be 1 only when the state is not IDLE and the phase counter is >= GAP_LEN.
REQ-020 P, Q and R SHALL change only on the edge entering a phase; BOP SHALL be 0 on that edge.
REQ-021 IDLE SHALL go to PH_W (counter 0) on the first edge where RST_N is high and stop is not requested.
REQ-022 BIT_CNT SHALL increment on each PH_Z->PH_W or PH_Z->IDLE transition, wrapping BIT_COUNT-1 -> 0.
REQ-023 WORD_STROBE SHALL be 1 for exactly the last cycle of PH_Z when BIT_CNT = BIT_COUNT-1.

Reset
REQ-024 While RST_N=0, the outputs SHALL be forced immediately:
- state = IDLE, counter = 0
- CGPP/CGQP/CGRP = 0, complements = 1
- BOP = 0, BIT_CNT = 0, WORD_STROBE = 0
REQ-025 Reset asserted mid-phase SHALL abort the phase with no completion, and BOP SHALL drop asynchronously.

Configuration
REQ-026 When CLKGEN_HALT_EN is defined, HALT SHALL be sampled only on the last cycle of PH_Z.
REQ-027 If HALT=1 when sampled, the next state SHALL be IDLE, with BIT_CNT updated per REQ-022.
REQ-028 In IDLE, the block SHALL go to PH_W on the first edge with HALT=0.
REQ-029 HALT toggling mid-bit SHALL have no effect, so a bit time is never truncated.
REQ-030 When CLKGEN_HALT_EN is undefined, the HALT port SHALL be absent and the block SHALL free-run; IDLE is reachable only via reset.

Structure
REQ-031 Package clkgen_pkg SHALL hold:
- the phase_t typedef (IDLE, PH_W, PH_X, PH_Y, PH_Z)
- the per-phase P/Q/R encoding constants
- the default PHASE_LEN, GAP_LEN and BIT_COUNT values
REQ-032 Sub-module clkgen_phase_timer SHALL hold the phase counter and its terminal-count and guard (count >= GAP_LEN) flags.

Verification
REQ-033 Reset release, defaults -> first edge enters PH_W with CGPP=1, CGQP=0, CGRP=1; BOP=0 for cycles 0-1 and 1 for cycles 2-7.
REQ-034 Free run -> W/X/Y/Z encodings per REQ-015; bit period 32 cycles; at every transition the complements are exact and BOP=0.
REQ-035 Run 448 cycles -> BIT_CNT wraps 13->0 and WORD_STROBE is high exactly once, on cycle 447.
REQ-036 RST_N pulsed low mid PH_X, counter=5 -> BOP and all CGxx drop asynchronously; restart begins at PH_W with BIT_CNT=0.
REQ-037 CLKGEN_HALT_EN, HALT=1 asserted in PH_X of bit 3 -> PH_Y and PH_Z complete, IDLE is entered with BIT_CNT=4 and BOP=0; HALT=0 -> next edge enters PH_W.
REQ-038 CLKGEN_HALT_EN, HALT pulsed in PH_W only -> no stop, sequence unchanged.
